cpu_control_unit: RTL and testbench

//  Multi-cycle sequencer for the 4-bit CPU. Fetches 16-bit instructions and decodes them.

---
 rtl/cpu_control_unit_pkg.sv | 47 ++++
 rtl/cpu_control_unit_dec.sv | 29 ++
 rtl/cpu_control_unit.sv | 96 +++++++++
 tb/tb_cpu_control_unit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_control_unit_pkg.sv
// Shared constants and types for the 4-bit CPU control unit: opcodes, ALU/write-select
// codes, FSM state encoding and the decoded-instruction bundle.
package cpu_control_unit_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_MOV  = 4'h6;
    localparam logic [3:0] OP_LDI  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_JZ   = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;

    localparam logic [1:0] WSEL_ALU = 2'd0;
    localparam logic [1:0] WSEL_RA  = 2'd1;
    localparam logic [1:0] WSEL_IMM = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef struct packed {
        logic [2:0] alu_op;
        logic [1:0] rf_wsel;
        logic       writes_rf;
        logic       updates_z;
        logic       is_jmp;
        logic       is_jz;
        logic       is_halt;
        logic       is_illegal;
    } dec_t;

endpackage

// File: rtl/cpu_control_unit_dec.sv
// Combinational opcode decoder: IR[15:12] to the control bundle used by the sequencer.
module cpu_control_unit_dec
    import cpu_control_unit_pkg::*;
(
    input  logic [3:0] i_opcode,
    output dec_t       o_dec
);

    always_comb begin
        o_dec         = '0;
        o_dec.alu_op  = ALU_ADD;
        o_dec.rf_wsel = WSEL_ALU;
        case (i_opcode)
            OP_NOP:  ;
            OP_ADD:  begin o_dec.alu_op = ALU_ADD; o_dec.writes_rf = 1'b1; o_dec.updates_z = 1'b1; end
            OP_SUB:  begin o_dec.alu_op = ALU_SUB; o_dec.writes_rf = 1'b1; o_dec.updates_z = 1'b1; end
            OP_AND:  begin o_dec.alu_op = ALU_AND; o_dec.writes_rf = 1'b1; o_dec.updates_z = 1'b1; end
            OP_OR:   begin o_dec.alu_op = ALU_OR;  o_dec.writes_rf = 1'b1; o_dec.updates_z = 1'b1; end
            OP_XOR:  begin o_dec.alu_op = ALU_XOR; o_dec.writes_rf = 1'b1; o_dec.updates_z = 1'b1; end
            OP_MOV:  begin o_dec.rf_wsel = WSEL_RA;  o_dec.writes_rf = 1'b1; end
            OP_LDI:  begin o_dec.rf_wsel = WSEL_IMM; o_dec.writes_rf = 1'b1; end
            OP_JMP:  o_dec.is_jmp  = 1'b1;
            OP_JZ:   o_dec.is_jz   = 1'b1;
            OP_HALT: o_dec.is_halt = 1'b1;
            default: o_dec.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the 4-bit CPU; owns pc, IR, zflag and
// the sticky illegal flag. All outputs are derived from state and IR only.
module cpu_control_unit
    import cpu_control_unit_pkg::*;
#(
    parameter int PC_WIDTH    = 8,
    parameter int RADDR_WIDTH = 3
) (
    input  logic                   i_clk,
    input  logic                   i_clr,
    input  logic                   i_start,
    input  logic [15:0]            i_instr_data,
    input  logic                   i_alu_zero,
    output logic [PC_WIDTH-1:0]    o_pc,
    output logic [RADDR_WIDTH-1:0] o_rf_addrD,
    output logic [RADDR_WIDTH-1:0] o_rf_addrA,
    output logic [RADDR_WIDTH-1:0] o_rf_addrB,
    output logic                   o_rf_load,
    output logic [1:0]             o_rf_wsel,
    output logic [3:0]             o_imm,
    output logic [2:0]             o_alu_op,
    output logic                   o_busy,
    output logic                   o_halted,
    output logic                   o_illegal
);

    state_t              r_state;
    state_t              w_next;
    logic [PC_WIDTH-1:0] r_pc;
    logic [15:0]         r_ir;
    logic                r_zflag;
    logic                r_illegal;
    dec_t                w_dec;
    logic [PC_WIDTH-1:0] w_pc_inc;
    logic [PC_WIDTH-1:0] w_target;

    cpu_control_unit_dec u_dec (
        .i_opcode (r_ir[15:12]),
        .o_dec    (w_dec)
    );

    assign w_pc_inc = r_pc + PC_WIDTH'(1);
    assign w_target = PC_WIDTH'(r_ir[7:0]);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (i_start) w_next = ST_FETCH;
            ST_FETCH:  w_next = ST_DECODE;
            ST_DECODE: w_next = ST_EXEC;
            ST_EXEC:   w_next = ST_WB;
            ST_WB:     w_next = w_dec.is_halt ? ST_HALT : ST_FETCH;
            ST_HALT:   w_next = ST_HALT;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_state   <= ST_IDLE;
            r_pc      <= '0;
            r_ir      <= '0;
            r_zflag   <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_FETCH)
                r_ir <= i_instr_data;
            if (r_state == ST_DECODE && w_dec.is_illegal)
                r_illegal <= 1'b1;
            if (r_state == ST_EXEC && w_dec.updates_z)
                r_zflag <= i_alu_zero;
            // JZ tests the flag latched by an earlier ALU op, never the live alu_zero.
            if (r_state == ST_WB) begin
                if (w_dec.is_jmp || (w_dec.is_jz && r_zflag))
                    r_pc <= w_target;
                else if (!w_dec.is_halt)
                    r_pc <= w_pc_inc;
            end
        end
    end

    assign o_pc       = r_pc;
    assign o_rf_addrD = RADDR_WIDTH'(r_ir[11:9]);
    assign o_rf_addrA = RADDR_WIDTH'(r_ir[8:6]);
    assign o_rf_addrB = RADDR_WIDTH'(r_ir[5:3]);
    assign o_imm      = r_ir[3:0];
    assign o_alu_op   = w_dec.alu_op;
    assign o_rf_wsel  = w_dec.rf_wsel;
    assign o_rf_load  = (r_state == ST_WB) && w_dec.writes_rf;
    assign o_busy     = (r_state == ST_FETCH) || (r_state == ST_DECODE) ||
                        (r_state == ST_EXEC)  || (r_state == ST_WB);
    assign o_halted   = (r_state == ST_HALT);
    assign o_illegal  = r_illegal;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit: a small program in a bench ROM, hand-computed
// expectations checked with immediate assertions.
module tb_cpu_control_unit;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        start = 1'b0;
    logic [15:0] instr_data;
    logic        alu_zero = 1'b0;
    logic [7:0]  pc;
    logic [2:0]  rf_addrD, rf_addrA, rf_addrB;
    logic        rf_load;
    logic [1:0]  rf_wsel;
    logic [3:0]  imm;
    logic [2:0]  alu_op;
    logic        busy, halted, illegal;

    logic [15:0] rom [256];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;
    assign instr_data = rom[pc];

    cpu_control_unit #(.PC_WIDTH(8), .RADDR_WIDTH(3)) dut (
        .i_clk        (clk),
        .i_clr        (clr),
        .i_start      (start),
        .i_instr_data (instr_data),
        .i_alu_zero   (alu_zero),
        .o_pc         (pc),
        .o_rf_addrD   (rf_addrD),
        .o_rf_addrA   (rf_addrA),
        .o_rf_addrB   (rf_addrB),
        .o_rf_load    (rf_load),
        .o_rf_wsel    (rf_wsel),
        .o_imm        (imm),
        .o_alu_op     (alu_op),
        .o_busy       (busy),
        .o_halted     (halted),
        .o_illegal    (illegal)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // From FETCH, advance to WB, checking rf_load stays low before WB.
    task automatic to_wb(input string nm, input logic z);
        alu_zero = z;
        chk({nm, "_fetch_busy"}, {31'd0, busy}, 32'd1);
        tick();
        chk({nm, "_dec_load"}, {31'd0, rf_load}, 32'd0);
        tick();
        chk({nm, "_exec_load"}, {31'd0, rf_load}, 32'd0);
        tick();
    endtask

    // From WB, step into the next FETCH and check the new pc.
    task automatic wb_out(input string nm, input logic exp_load, input logic [7:0] exp_pc);
        chk({nm, "_wb_load"}, {31'd0, rf_load}, {31'd0, exp_load});
        tick();
        chk({nm, "_pc"}, {24'd0, pc}, {24'd0, exp_pc});
        chk({nm, "_post_load"}, {31'd0, rf_load}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        rom[8'h00] = 16'h7205;  // LDI r1,5
        rom[8'h01] = 16'h1650;  // ADD r3,r1,r2
        rom[8'h02] = 16'h2000;  // SUB, zero result
        rom[8'h03] = 16'h6040;  // MOV r0,r1
        rom[8'h04] = 16'h9020;  // JZ 0x20 (taken)
        rom[8'h20] = 16'h2000;  // SUB, nonzero result
        rom[8'h21] = 16'h9030;  // JZ 0x30 (not taken)
        rom[8'h22] = 16'h80FF;  // JMP 0xFF
        rom[8'hFF] = 16'h0000;  // NOP, pc wraps
        rom[8'hAB] = 16'hC000;  // illegal
        rom[8'hAC] = 16'hF000;  // HALT

        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("rst_pc", {24'd0, pc}, 32'd0);
        chk("rst_flags", {28'd0, rf_load, busy, halted, illegal}, 32'd0);
        chk("rst_fields", {16'd0, rf_addrD, rf_addrA, rf_addrB, rf_wsel, imm}, 32'd0);
        chk("rst_aluop", {29'd0, alu_op}, 32'd0);
        tick();
        chk("idle_no_start", {31'd0, busy}, 32'd0);

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("fetch_pc0", {24'd0, pc}, 32'd0);
        to_wb("ldi", 1'b1);
        chk("ldi_wb_fields", {23'd0, rf_addrD, rf_wsel, imm}, {23'd0, 3'd1, 2'd2, 4'd5});
        chk("ldi_wb_pc", {24'd0, pc}, 32'd0);
        wb_out("ldi", 1'b1, 8'h01);

        to_wb("add", 1'b0);
        chk("add_wb_fields", {20'd0, alu_op, rf_addrA, rf_addrB, rf_addrD}, {20'd0, 3'd0, 3'd1, 3'd2, 3'd3});
        chk("add_wb_wsel", {30'd0, rf_wsel}, 32'd0);
        wb_out("add", 1'b1, 8'h02);

        to_wb("sub_z", 1'b1);
        chk("sub_aluop", {29'd0, alu_op}, 32'd1);
        wb_out("sub_z", 1'b1, 8'h03);
        to_wb("mov", 1'b0);
        chk("mov_wsel", {26'd0, rf_wsel, rf_addrA}, {26'd0, 2'd1, 3'd1});
        wb_out("mov", 1'b1, 8'h04);
        to_wb("jz_taken", 1'b0);
        wb_out("jz_taken", 1'b0, 8'h20);

        to_wb("sub_nz", 1'b0);
        wb_out("sub_nz", 1'b1, 8'h21);
        to_wb("jz_not", 1'b1);
        wb_out("jz_not", 1'b0, 8'h22);

        to_wb("jmp_ff", 1'b0);
        wb_out("jmp_ff", 1'b0, 8'hFF);
        to_wb("nop_wrap", 1'b0);
        rom[8'h00] = 16'h80AB;  // JMP 0xAB for the wrapped pass
        wb_out("nop_wrap", 1'b0, 8'h00);
        to_wb("jmp_ab", 1'b0);
        wb_out("jmp_ab", 1'b0, 8'hAB);

        tick();
        chk("ill_decode", {31'd0, illegal}, 32'd0);
        tick();
        chk("ill_exec", {31'd0, illegal}, 32'd1);
        tick();
        wb_out("ill", 1'b0, 8'hAC);
        chk("ill_sticky", {31'd0, illegal}, 32'd1);

        to_wb("halt", 1'b0);
        chk("halt_wb", {29'd0, rf_load, busy, halted}, {29'd0, 3'b010});
        tick();
        chk("halt_state", {29'd0, rf_load, busy, halted}, {29'd0, 3'b001});
        chk("halt_pc", {24'd0, pc}, 32'h0000_00AC);
        start = 1'b1;
        tick(); tick(); tick();
        start = 1'b0;
        chk("halt_absorb", {29'd0, halted, busy, illegal}, {29'd0, 3'b101});
        chk("halt_absorb_pc", {24'd0, pc}, 32'h0000_00AC);

        rom[8'h00] = 16'hC000;  // illegal, then ADD
        rom[8'h01] = 16'h1650;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_halt", {28'd0, halted, busy, illegal, rf_load}, 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        to_wb("ill2", 1'b0);
        wb_out("ill2", 1'b0, 8'h01);
        to_wb("add_clr", 1'b0);
        chk("add_clr_wb_load", {30'd0, rf_load, illegal}, {30'd0, 2'b11});
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_wb_flags", {28'd0, rf_load, busy, halted, illegal}, 32'd0);
        chk("clr_wb_pc", {24'd0, pc}, 32'd0);
        tick();
        chk("clr_wb_idle", {30'd0, busy, rf_load}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
